dummy_ip_s00_axi_regs: RTL and testbench
========================================

// Module: dummy_ip_s00_axi_regs
// PURPOSE
//  AXI4-Lite slave register file behind the dummy_ip S00_AXI port. It is the responder the master VIP bench drives.
//  Holds NUM_REGS read/write 32-bit registers and applies byte strobes. Decodes the word index and returns OKAY/SLVERR.
//  Exposes all register contents to user logic on a flat output bus.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  6   byte address width; word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]
//  NUM_REGS            4   implemented registers, at byte offsets 0x0, 0x4, 0x8, 0xC
// PORTS
//  S_AXI_ACLK     in   1          clock; everything is on the rising edge
//  S_AXI_ARESETN  in   1          asynchronous, active-low reset
//  S_AXI_AWADDR   in   ADDR_W     write address
//  S_AXI_AWPROT   in   3          ignored
//  S_AXI_AWVALID  in   1          write address valid
//  S_AXI_AWREADY  out  1          write address ready
//  S_AXI_WDATA    in   32         write data
//  S_AXI_WSTRB    in   4          byte enables; bit k enables WDATA[8k+7:8k]
//  S_AXI_WVALID   in   1          write data valid
//  S_AXI_WREADY   out  1          write data ready
//  S_AXI_BRESP    out  2          write response: 2'b00 OKAY, 2'b10 SLVERR
//  S_AXI_BVALID   out  1          write response valid
//  S_AXI_BREADY   in   1          write response ready
//  S_AXI_ARADDR   in   ADDR_W     read address
//  S_AXI_ARPROT   in   3          ignored
//  S_AXI_ARVALID  in   1          read address valid
//  S_AXI_ARREADY  out  1          read address ready
//  S_AXI_RDATA    out  32         read data
//  S_AXI_RRESP    out  2          read response
//  S_AXI_RVALID   out  1          read data valid
//  S_AXI_RREADY   in   1          read data ready
//  REG_OUT        out  32*NUM_REGS  register i is on bits [32i+31:32i]
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All registers, BVALID, RVALID, RDATA, BRESP, RRESP and the hold flags clear to 0.
//   - Any in-flight transaction is discarded. AWREADY, WREADY and ARREADY are 1 from the first edge after release.
//  Write channel: at most one write outstanding.
//   - Address and data hold flags aw_held and w_held. AWREADY = !aw_held and WREADY = !w_held, both registered.
//   - The AW and W handshakes are independent; either may come first, or both in the same cycle.
//   - The edge after both flags are set (BVALID=0): commit the write and set BVALID.
//     An AW and W handshake at edge N therefore gives BVALID=1 after edge N+1.
//   - Commit: reg[idx] byte k = WDATA byte k wherever WSTRB[k]=1; other bytes keep their value.
//   - BVALID and BRESP stay stable until BREADY. The B handshake clears BVALID, aw_held and w_held, so readies return next cycle.
//  Read channel: at most one read outstanding.
//   - ARREADY = !RVALID.
//   - AR handshake at edge N: RDATA/RRESP are registered from the current register contents and RVALID=1 after edge N.
//   - RDATA, RRESP and RVALID are held until the R handshake, which clears RVALID.
//  Decode:
//   - idx >= NUM_REGS gives SLVERR. The write is discarded (no state change) and the read returns RDATA=0.
//   - ADDR[1:0] is ignored.
//  Simultaneous events:
//   - Read and write channels run concurrently.
//   - A read captured on the same edge a write commits to the same register returns the pre-write value.
//  REG_OUT reflects the register contents directly, with no extra latency.
// TESTING
//  1. After reset, write 0x1..0x4 to 0x0, 0x4, 0x8 and 0xC (WSTRB=0xF), then read back -> data matches, BRESP=RRESP=OKAY.
//  2. WVALID raised 3 cycles before AWVALID -> WREADY drops after the W handshake; BVALID is 1 the edge after the AW handshake; reg written.
//  3. reg1=0x11223344, write 0xAABBCCDD with WSTRB=4'b0010 -> read gives 0x1122CC44.
//  4. Hold BREADY=0 for 5 cycles -> BVALID stays 1 and AWREADY=WREADY=0; a second write is accepted only after the B handshake.
//  5. Write/read at 0x10 -> BRESP=RRESP=2'b10, RDATA=0, REG_OUT unchanged; a same-edge read/write on reg2 returns the old value.
//  6. Drive ARESETN=0 while RVALID=1 and a write is half-captured -> RVALID, BVALID and REG_OUT go to 0 immediately; after release, a fresh write/read works.

Source files
------------

// File: rtl/dummy_ip_s00_axi_regs.sv
// dummy_ip_s00_axi_regs: AXI4-Lite slave register file for the dummy_ip S00_AXI port.
// NUM_REGS r/w words with byte strobes. Out-of-range word indexes return SLVERR.
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset;
//   AW/W/B: write address, data with strobes, and response channels;
//   AR/R: read address and data channels;
//   REG_OUT: all registers, register i on bits [32i+31:32i].
module dummy_ip_s00_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_REGS           = 4
) (
   input  logic                                   S_AXI_ACLK,
   input  logic                                   S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] REG_OUT
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic          aw_held, w_held;
   logic          awready_q, wready_q, arready_q;
   logic          bvalid_q, rvalid_q;
   logic [IW-1:0] waddr_q;
   logic [DW-1:0] wdata_q;
   logic [SW-1:0] wstrb_q;
   logic [1:0]    bresp_q, rresp_q;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] regs [NUM_REGS];

   logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
   logic          aw_held_nxt, w_held_nxt, rvalid_nxt;
   logic [IW-1:0] raddr;
   logic          w_hit, r_hit;
   logic [DW-1:0] rd_word;

   // Protection bits and the byte offset within a word carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign raddr  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   assign aw_hs  = S_AXI_AWVALID && awready_q;
   assign w_hs   = S_AXI_WVALID && wready_q;
   assign b_hs   = bvalid_q && S_AXI_BREADY;
   assign ar_hs  = S_AXI_ARVALID && arready_q;
   assign r_hs   = rvalid_q && S_AXI_RREADY;
   // Both halves captured and no response pending: commit exactly once.
   assign commit = aw_held && w_held && !bvalid_q;

   // Hold flags stay set through the response so readies remain low
   // until the B handshake retires the write.
   assign aw_held_nxt = b_hs ? 1'b0 : (aw_held || aw_hs);
   assign w_held_nxt  = b_hs ? 1'b0 : (w_held || w_hs);
   assign rvalid_nxt  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);

   always_comb begin
      w_hit   = 1'b0;
      r_hit   = 1'b0;
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (waddr_q == IW'(i)) w_hit = 1'b1;
         if (raddr == IW'(i)) begin
            r_hit   = 1'b1;
            rd_word = regs[i];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         aw_held   <= aw_held_nxt;
         w_held    <= w_held_nxt;
         awready_q <= !aw_held_nxt;
         wready_q  <= !w_held_nxt;
         rvalid_q  <= rvalid_nxt;
         arready_q <= !rvalid_nxt;
         if (aw_hs) waddr_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= w_hit ? RESP_OKAY : RESP_SLVERR;
         end else if (b_hs) begin
            bvalid_q <= 1'b0;
         end
         if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Reads capture on the same edge as a commit, so they see the old value.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr_q == IW'(i)) begin
               for (int k = 0; k < SW; k++) begin
                  if (wstrb_q[k]) regs[i][8*k +: 8] <= wdata_q[8*k +: 8];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign REG_OUT[g*DW +: DW] = regs[g];
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_dummy_ip_s00_axi_regs.sv
// tb_dummy_ip_s00_axi_regs: directed and randomized AXI4-Lite traffic
// against a word-array reference model of the register file.
module tb_dummy_ip_s00_axi_regs;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [5:0]   awaddr = '0;
   logic [2:0]   awprot = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b0;
   logic [5:0]   araddr = '0;
   logic [2:0]   arprot = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b0;
   logic [127:0] reg_out;

   int checks = 0;
   int failures = 0;

   logic [31:0] mdl [4];

   always #5 clk = ~clk;

   dummy_ip_s00_axi_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(6),
      .NUM_REGS(4)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr),
      .S_AXI_AWPROT(awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata),
      .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp),
      .S_AXI_BVALID(bvalid),
      .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr),
      .S_AXI_ARPROT(arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata),
      .S_AXI_RRESP(rresp),
      .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready),
      .REG_OUT(reg_out)
   );

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] flat();
      logic [127:0] f;
      f = {mdl[3], mdl[2], mdl[1], mdl[0]};
      return f;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [5:0] a);
      return (a[5:2] < 4) ? 2'b00 : 2'b10;
   endfunction

   function automatic void mdl_write(input logic [5:0] a,
                                     input logic [31:0] d,
                                     input logic [3:0] s);
      int idx;
      idx = int'(a[5:2]);
      if (idx < 4) begin
         for (int k = 0; k < 4; k++)
            if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
      end
   endfunction

   function automatic logic [31:0] mdl_read(input logic [5:0] a);
      int idx;
      idx = int'(a[5:2]);
      return (idx < 4) ? mdl[idx] : 32'h0;
   endfunction

   // Called and returns at a negedge; AW/W raised after their delays.
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int awd,
                            input int wd, output logic [1:0] resp);
      int n;
      bit ao, wo;
      n = 0; ao = 0; wo = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(ao && wo) && n < 40) begin
         awvalid = !ao && n >= awd;
         wvalid  = !wo && n >= wd;
         if (awvalid && awready) ao = 1;
         if (wvalid && wready) wo = 1;
         @(negedge clk);
         n++;
      end
      awvalid = 1'b0;
      wvalid = 1'b0;
      chk("wr_handshake", {ao, wo}, 2'b11);
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b_valid", bvalid, 1'b1);
      resp = bresp;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      int n;
      n = 0;
      araddr = a;
      arvalid = 1'b1;
      while (!arready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ar_ready", arready, 1'b1);
      @(negedge clk);
      arvalid = 1'b0;
      chk("r_valid", rvalid, 1'b1);
      d = rdata;
      resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [5:0]  a;
      logic [31:0] v;
      logic [3:0]  s;

      for (int i = 0; i < 4; i++) mdl[i] = '0;

      repeat (3) @(negedge clk);
      chk("rst_regout", reg_out, 128'h0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_readies", {awready, wready, arready}, 3'b111);

      // Basic write then read back of every register.
      for (int i = 0; i < 4; i++) begin
         a = 6'(4 * i);
         axi_write(a, 32'(i + 1), 4'hF, 0, 0, r);
         mdl_write(a, 32'(i + 1), 4'hF);
         chk("t1_bresp", r, 2'b00);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(6'(4 * i), d, r);
         chk("t1_rdata", d, 32'(i + 1));
         chk("t1_rresp", r, 2'b00);
      end
      chk("t1_regout", reg_out, flat());

      // W leads AW by three cycles.
      wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1'b1;
      chk("t2_wready0", wready, 1'b1);
      @(negedge clk);
      wvalid = 1'b0;
      chk("t2_wready_drop", wready, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("t2_bvalid_early", bvalid, 1'b0);
      awaddr = 6'h04; awvalid = 1'b1;
      chk("t2_awready", awready, 1'b1);
      @(negedge clk);
      awvalid = 1'b0;
      chk("t2_bvalid_n", bvalid, 1'b0);
      @(negedge clk);
      chk("t2_bvalid_n1", bvalid, 1'b1);
      mdl_write(6'h04, 32'hCAFE_0001, 4'hF);
      chk("t2_regout", reg_out, flat());
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("t2_bvalid_clr", bvalid, 1'b0);

      // Byte strobes.
      axi_write(6'h04, 32'h1122_3344, 4'hF, 0, 0, r);
      mdl_write(6'h04, 32'h1122_3344, 4'hF);
      axi_write(6'h04, 32'hAABB_CCDD, 4'b0010, 1, 0, r);
      mdl_write(6'h04, 32'hAABB_CCDD, 4'b0010);
      axi_read(6'h04, d, r);
      chk("t3_strb_lit", d, 32'h1122_CC44);
      chk("t3_strb_mdl", d, mdl[1]);

      // Response back-pressure with a second write presented meanwhile.
      awaddr = 6'h0C; awvalid = 1'b1;
      wdata = 32'h0000_00A1; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wdata = 32'h0000_00B2;
      chk("t4_awready_busy", awready, 1'b0);
      @(negedge clk);
      mdl_write(6'h0C, 32'h0000_00A1, 4'hF);
      for (int i = 0; i < 5; i++) begin
         chk("t4_bvalid_hold", bvalid, 1'b1);
         chk("t4_readies_low", {awready, wready}, 2'b00);
         chk("t4_reg_first", reg_out, flat());
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("t4_readies_back", {awready, wready}, 2'b11);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("t4_bvalid2", bvalid, 1'b1);
      mdl_write(6'h0C, 32'h0000_00B2, 4'hF);
      chk("t4_reg_second", reg_out, flat());
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;

      // Out-of-range accesses.
      axi_write(6'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
      chk("t5_bresp_err", r, 2'b10);
      chk("t5_regout_keep", reg_out, flat());
      axi_read(6'h10, d, r);
      chk("t5_rresp_err", r, 2'b10);
      chk("t5_rdata_zero", d, 32'h0);

      // Read captured on the commit edge of a write to the same register.
      v = mdl[2];
      awaddr = 6'h08; awvalid = 1'b1;
      wdata = 32'h5A5A_0F0F; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 6'h08; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      mdl_write(6'h08, 32'h5A5A_0F0F, 4'hF);
      chk("t5_same_rvalid", {rvalid, bvalid}, 2'b11);
      chk("t5_same_old", rdata, v);
      chk("t5_same_reg", reg_out, flat());
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         a = {4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         v = $urandom;
         s = 4'($urandom_range(0, 15));
         axi_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
         mdl_write(a, v, s);
         chk("rnd_bresp", r, exp_resp(a));
         chk("rnd_regout", reg_out, flat());
         a = {4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         axi_read(a, d, r);
         chk("rnd_rdata", d, mdl_read(a));
         chk("rnd_rresp", r, exp_resp(a));
      end

      // Reset with a pending read response and a half-captured write.
      araddr = 6'h04; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk("t6_rvalid_pre", rvalid, 1'b1);
      awaddr = 6'h00; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      chk("t6_rvalid_rst", rvalid, 1'b0);
      chk("t6_bvalid_rst", bvalid, 1'b0);
      chk("t6_regout_rst", reg_out, flat());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_readies", {awready, wready, arready}, 3'b111);
      axi_write(6'h08, 32'h0BAD_F00D, 4'hF, 0, 0, r);
      mdl_write(6'h08, 32'h0BAD_F00D, 4'hF);
      chk("t6_bresp", r, 2'b00);
      axi_read(6'h08, d, r);
      chk("t6_rdata", d, mdl[2]);
      chk("t6_regout", reg_out, flat());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
